bcd_to_bin_seq: RTL and testbench

- Parametrised sequential successor to the fixed 3-digit weighted converter.
- Converts NDIGITS packed BCD digits (switch/keypad input) into an OUT_W-bit binary word by iterative multiply-by-10 accumulation, one digit per cycle.
- Adds valid/ready handshakes, an optional negate mode, and invalid-digit and overflow flags.
- Sits between the input-device debouncer and the CPU's MMIO read port.

---
 rtl/bcd_to_bin_seq.sv | 109 ++++++++++
 tb/tb_bcd_to_bin_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per cycle by shift-and-add
// multiply-by-10, with valid/ready handshakes, optional negation and error flags.
module bcd_to_bin_seq #(
    parameter int NDIGITS = 8,
    parameter int OUT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS-1:0]   digits,
    input  logic                   neg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       result,
    output logic                   err,
    output logic                   ovf
);

    localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                 state;
    logic [4*NDIGITS-1:0]   dig_q;
    logic                   neg_q;
    logic [OUT_W-1:0]       acc;
    logic [CNT_W-1:0]       cnt;

    logic [3:0]             nib;
    logic [OUT_W+3:0]       acc_ext;
    logic [OUT_W+3:0]       acc_next;
    logic [OUT_W-1:0]       acc_low;
    logic                   hi_nz;
    logic                   err_next;
    logic                   ovf_next;

    function automatic logic [OUT_W-1:0] apply_sign(input logic [OUT_W-1:0] mag,
                                                    input logic            negate);
        apply_sign = negate ? (~mag + 1'b1) : mag;
    endfunction

    // acc*10 + digit as (acc<<3)+(acc<<1)+digit, wide enough that nothing is lost
    always_comb begin
        nib      = dig_q[4*int'(cnt) +: 4];
        acc_ext  = {4'b0000, acc};
        acc_next = (acc_ext << 3) + (acc_ext << 1) + {{OUT_W{1'b0}}, nib};
        acc_low  = acc_next[OUT_W-1:0];
        hi_nz    = |acc_next[OUT_W+3:OUT_W];
        err_next = err | (nib > 4'd9);
        ovf_next = ovf | hi_nz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            dig_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        dig_q    <= digits;
                        neg_q    <= neg;
                        acc      <= '0;
                        err      <= 1'b0;
                        ovf      <= 1'b0;
                        cnt      <= CNT_W'(NDIGITS - 1);
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc <= acc_low;
                    err <= err_next;
                    ovf <= ovf_next;
                    if (cnt == '0) begin
                        // sign applied after overflow evaluation so ovf reflects magnitude
                        result    <= apply_sign(acc_low, neg_q);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: 32-bit and 16-bit result instances,
// directed vectors with hand-computed expectations checked by per-instance monitors.
module tb_bcd_to_bin_seq;

    typedef struct {
        logic [31:0] r;
        logic        e;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid32, in_ready32, neg32, out_valid32, out_ready32, err32, ovf32;
    logic [31:0] digits32;
    logic [31:0] result32;

    logic        in_valid16, in_ready16, neg16, out_valid16, out_ready16, err16, ovf16;
    logic [31:0] digits16;
    logic [15:0] result16;

    exp_t q32[$];
    exp_t q16[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.NDIGITS(8), .OUT_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .digits(digits32), .neg(neg32), .out_valid(out_valid32), .out_ready(out_ready32),
        .result(result32), .err(err32), .ovf(ovf32)
    );

    bcd_to_bin_seq #(.NDIGITS(8), .OUT_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .digits(digits16), .neg(neg16), .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .err(err16), .ovf(ovf16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitors sample mid-cycle; a beat seen here is consumed at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid32 && out_ready32) begin
            if (q32.size() == 0) begin
                check("unexpected_out32", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = q32.pop_front();
                check("result32", result32, x.r);
                check("err32", {31'd0, err32}, {31'd0, x.e});
                check("ovf32", {31'd0, ovf32}, {31'd0, x.o});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                check("unexpected_out16", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = q16.pop_front();
                check("result16", {16'd0, result16}, x.r);
                check("err16", {31'd0, err16}, {31'd0, x.e});
                check("ovf16", {31'd0, ovf16}, {31'd0, x.o});
            end
        end
    end

    task automatic send32(input logic [31:0] d, input logic n, input logic [31:0] r,
                          input logic e, input logic o, input bit push);
        int guard = 0;
        while (!in_ready32 && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready32) check("in_ready32_timeout", 32'd0, 32'd1);
        digits32   = d;
        neg32      = n;
        in_valid32 = 1'b1;
        if (push) q32.push_back('{r, e, o});
        tick();
        in_valid32 = 1'b0;
        digits32   = ~d;
        neg32      = ~n;
    endtask

    task automatic send16(input logic [31:0] d, input logic n, input logic [31:0] r,
                          input logic e, input logic o);
        int guard = 0;
        while (!in_ready16 && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready16) check("in_ready16_timeout", 32'd0, 32'd1);
        digits16   = d;
        neg16      = n;
        in_valid16 = 1'b1;
        q16.push_back('{r, e, o});
        tick();
        in_valid16 = 1'b0;
        digits16   = ~d;
        neg16      = ~n;
    endtask

    task automatic wait_out32(output int n);
        n = 0;
        while (!out_valid32 && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid32) check("out_valid32_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        in_valid32 = 1'b0; neg32 = 1'b0; digits32 = '0; out_ready32 = 1'b1;
        in_valid16 = 1'b0; neg16 = 1'b0; digits16 = '0; out_ready16 = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready32}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid32}, 32'd0);
        check("rst_result", result32, 32'd0);
        check("rst_err_ovf", {30'd0, err32, ovf32}, 32'd0);
        rst = 1'b0;
        tick();

        // DONE is entered on the 8th edge after acceptance
        send32(32'h12345678, 1'b0, 32'h00BC614E, 1'b0, 1'b0, 1'b1);
        wait_out32(lat);
        check("latency_edges", lat, 32'd8);

        send32(32'h99999999, 1'b0, 32'h05F5E0FF, 1'b0, 1'b0, 1'b1);
        send32(32'h00000042, 1'b1, 32'hFFFFFFD6, 1'b0, 1'b0, 1'b1);
        // 10 weighted at 10^3 plus 1 = 10001
        send32(32'h0000A001, 1'b0, 32'h00002711, 1'b1, 1'b0, 1'b1);
        send32(32'h00000007, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b1);
        send32(32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);

        send16(32'h00065535, 1'b0, 32'h0000FFFF, 1'b0, 1'b0);
        send16(32'h00065536, 1'b0, 32'h00000000, 1'b0, 1'b1);

        // Backpressure: DONE holds while out_ready is low
        out_ready32 = 1'b0;
        send32(32'h00000314, 1'b0, 32'h0000013A, 1'b0, 1'b0, 1'b1);
        wait_out32(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid32 = i[0];
            digits32   = 32'h11111111 * i;
            tick();
            check("stall_result", result32, 32'h0000013A);
            check("stall_in_ready", {31'd0, in_ready32}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid32}, 32'd1);
        end
        in_valid32  = 1'b0;
        out_ready32 = 1'b1;
        tick();
        check("release_out_valid", {31'd0, out_valid32}, 32'd0);
        check("release_in_ready", {31'd0, in_ready32}, 32'd1);

        // Reset during conversion discards the pending result
        send32(32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", {31'd0, out_valid32}, 32'd0);
        check("abort_result", result32, 32'd0);
        check("abort_in_ready", {31'd0, in_ready32}, 32'd1);
        send32(32'h00000005, 1'b0, 32'h00000005, 1'b0, 1'b0, 1'b1);
        wait_out32(lat);
        check("post_abort_latency", lat, 32'd8);

        for (int i = 0; i < 30; i++) tick();
        check("q32_drained", q32.size(), 32'd0);
        check("q16_drained", q16.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
